// File: rtl/serial_word_framer_pkg.sv
// Shared constants for the serial word framer and the downstream
// divisible-by-5 checker bench: state encodings and the state type.
package serial_word_framer_pkg;

  // Binary-encoded framer states; values are stable so other benches can decode them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/frame_counter.sv
// Free-running wrap counter: advances by one on each enabled cycle and
// rolls over to zero after 2^CNT_W-1.
module frame_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; natural overflow gives the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/serial_word_framer.sv
// Serial word framer: accepts a parallel word, pulses a clear to the
// downstream checker, shifts the word out MSB-first and strobes frame_done
// when the checker result covers the whole word.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE; in_data/in_valid are ignored
// in every other state, and nothing is queued.
module serial_word_framer
  import serial_word_framer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fsm_clr,
  output logic             ser_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_sent,
  output state_t           dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and outputs; outputs depend only on state and flops.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    fsm_clr    = 1'b0;
    ser_out    = 1'b0;
    bit_valid  = 1'b0;
    frame_last = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        fsm_clr    = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_valid  = 1'b1;
        ser_out    = shreg[WIDTH-1];
        frame_last = (bit_cnt == BIT_LAST);
        if (bit_cnt == BIT_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch the word on accept, shift it during SHIFT, time the gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg   <= in_data;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          // Hold on the last bit so the counter never passes WIDTH-1.
          if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
        end
        ST_DONE: gap_cnt <= '0;
        ST_GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_DONE),
    .count (frames_sent)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_serial_word_framer.sv
// Bench for serial_word_framer: two instances (gap of 1 with a 16-bit
// counter, no gap with a 4-bit counter) feeding behavioural models of the
// divisible-by-5 checker (reset = reset | fsm_clr, x = ser_out).
module tb_serial_word_framer;
  import serial_word_framer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_sent_a = 0;

  // Instance A signals.
  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready, a_fsm_clr, a_ser_out, a_bit_valid;
  logic        a_frame_last, a_frame_done;
  logic [15:0] a_frames_sent;
  state_t      a_dbg_state;

  // Instance B signals.
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_fsm_clr, b_ser_out, b_bit_valid;
  logic        b_frame_last, b_frame_done;
  logic [3:0]  b_frames_sent;
  state_t      b_dbg_state;

  logic [7:0] exp_q[$];

  // Clock / reset block.
  always #5 clk = ~clk;

  serial_word_framer #(.WIDTH(8), .GAP_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .fsm_clr(a_fsm_clr), .ser_out(a_ser_out),
    .bit_valid(a_bit_valid), .frame_last(a_frame_last), .frame_done(a_frame_done),
    .frames_sent(a_frames_sent), .dbg_state(a_dbg_state)
  );

  serial_word_framer #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .fsm_clr(b_fsm_clr), .ser_out(b_ser_out),
    .bit_valid(b_bit_valid), .frame_last(b_frame_last), .frame_done(b_frame_done),
    .frames_sent(b_frames_sent), .dbg_state(b_dbg_state)
  );

  // Checker model: running value of the received bit stream modulo 5; y = (rem == 0).
  int rem_a, rem_b;
  always @(posedge clk or posedge reset) begin
    if (reset || a_fsm_clr) rem_a <= 0;
    else                    rem_a <= (rem_a * 2 + int'(a_ser_out)) % 5;
    if (reset || b_fsm_clr) rem_b <= 0;
    else                    rem_b <= (rem_b * 2 + int'(b_ser_out)) % 5;
  end

  // Driver: present one word to instance A and record what comes back until frame_done.
  task automatic capture_a(input logic [7:0] d, input bit toggle,
                           output logic [7:0] bits, output int nbits, output int lat,
                           output int last_pos, output int last_cnt, output logic y,
                           output bit timeout);
    int c;
    int w;
    timeout = 0; bits = '0; nbits = 0; lat = -1; last_pos = -1; last_cnt = 0; y = 1'b0;
    w = 0;
    while (!a_in_ready && w < 50) begin @(negedge clk); w++; end
    if (!a_in_ready) begin timeout = 1; return; end
    a_in_data = d; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    c = 0;
    while (c < 40) begin
      if (a_bit_valid) begin
        bits = {bits[6:0], a_ser_out};
        nbits++;
        if (a_frame_last) begin last_pos = nbits; last_cnt++; end
      end else if (a_frame_last) last_cnt++;
      if (a_frame_done) begin lat = c; y = (rem_a == 0); break; end
      if (toggle) a_in_data = 8'($urandom);
      @(negedge clk);
      c++;
    end
    if (lat < 0) timeout = 1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({a_in_ready, a_fsm_clr, a_ser_out, a_bit_valid, a_frame_last, a_frame_done} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got %b want 100000",
               {a_in_ready, a_fsm_clr, a_ser_out, a_bit_valid, a_frame_last, a_frame_done});
    end
    tests_run++;
    if (a_frames_sent !== 16'd0 || b_frames_sent !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_frames_sent: got a=%0d b=%0d want 0", a_frames_sent, b_frames_sent);
    end
    tests_run++;
    if (a_dbg_state !== ST_IDLE || b_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got state=%0d b_ready=%b want 0/1", a_dbg_state, b_in_ready);
    end
  endtask

  // Directed words 10 and 7 followed by random words through instance A.
  task automatic test_single_words();
    logic [7:0] words[12];
    logic [7:0] bits;
    int nbits, lat, last_pos, last_cnt;
    logic y;
    bit to;
    words[0] = 8'd10;
    words[1] = 8'd7;
    for (int i = 2; i < 12; i++) words[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) begin
      capture_a(words[i], 1'b0, bits, nbits, lat, last_pos, last_cnt, y, to);
      tests_run++;
      if (to) begin
        tests_failed++;
        $display("FAIL word_timeout[%0d]: no frame_done for %0d", i, words[i]);
        continue;
      end
      tests_run++;
      if (bits !== words[i] || nbits != 8) begin
        tests_failed++;
        $display("FAIL word_bits[%0d]: got %b (%0d bits) want %b (8 bits)", i, bits, nbits, words[i]);
      end
      tests_run++;
      if (last_pos != 8 || last_cnt != 1) begin
        tests_failed++;
        $display("FAIL word_last[%0d]: got pos=%0d count=%0d want pos=8 count=1", i, last_pos, last_cnt);
      end
      tests_run++;
      if (lat != 9) begin
        tests_failed++;
        $display("FAIL word_latency[%0d]: got %0d want 9", i, lat);
      end
      tests_run++;
      if (y !== ((words[i] % 5) == 0)) begin
        tests_failed++;
        $display("FAIL word_y[%0d]: data=%0d got y=%b want %b", i, words[i], y, (words[i] % 5) == 0);
      end
      @(negedge clk);
      exp_sent_a++;
      tests_run++;
      if (a_frames_sent !== 16'(exp_sent_a)) begin
        tests_failed++;
        $display("FAIL word_frames_sent[%0d]: got %0d want %0d", i, a_frames_sent, exp_sent_a);
      end
    end
  endtask

  // in_data scrambled every cycle after accept; the latched word must come out.
  task automatic test_toggle();
    logic [7:0] bits, d;
    int nbits, lat, last_pos, last_cnt;
    logic y;
    bit to;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      capture_a(d, 1'b1, bits, nbits, lat, last_pos, last_cnt, y, to);
      tests_run++;
      if (to || bits !== d || nbits != 8) begin
        tests_failed++;
        $display("FAIL toggle_bits[%0d]: got %b (%0d bits, timeout=%0d) want %b", i, bits, nbits, to, d);
      end
      @(negedge clk);
      exp_sent_a++;
    end
  endtask

  // in_valid held high: 255 then 20, accept-to-accept period is 12.
  task automatic test_back_to_back();
    int acc0, acc1, nacc, ndone;
    acc0 = -1; acc1 = -1; nacc = 0; ndone = 0;
    while (!a_in_ready) @(negedge clk);
    a_in_data = 8'd255; a_in_valid = 1'b1;
    for (int t = 0; t < 80 && ndone < 2; t++) begin
      if (a_frame_done) begin
        ndone++;
        tests_run++;
        if (rem_a != 0) begin
          tests_failed++;
          $display("FAIL b2b_y[%0d]: got y=0 want 1", ndone);
        end
      end
      if (a_in_ready && a_in_valid) begin
        if (nacc == 0) acc0 = t; else acc1 = t;
        nacc++;
      end else if (!a_in_ready) begin
        if (nacc == 1) a_in_data = 8'd20;
        if (nacc == 2) a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    tests_run++;
    if (ndone != 2 || acc1 - acc0 != 12) begin
      tests_failed++;
      $display("FAIL b2b_period: got period=%0d dones=%0d want 12/2", acc1 - acc0, ndone);
    end
    @(negedge clk);
    exp_sent_a += 2;
    tests_run++;
    if (a_frames_sent !== 16'(exp_sent_a)) begin
      tests_failed++;
      $display("FAIL b2b_frames_sent: got %0d want %0d", a_frames_sent, exp_sent_a);
    end
  endtask

  // Reset during the 4th shift cycle discards the word.
  task automatic test_reset_midframe();
    int nb, w, dones;
    while (!a_in_ready) @(negedge clk);
    a_in_data = 8'($urandom_range(0, 255)); a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    nb = 0; w = 0;
    while (nb < 4 && w < 20) begin
      @(negedge clk);
      w++;
      if (a_bit_valid) nb++;
    end
    tests_run++;
    if (nb != 4) begin
      tests_failed++;
      $display("FAIL midreset_reach: got %0d shift cycles want 4", nb);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({a_in_ready, a_ser_out, a_bit_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midreset_async: got ready/ser/bv=%b want 100", {a_in_ready, a_ser_out, a_bit_valid});
    end
    @(negedge clk);
    tests_run++;
    if ({a_in_ready, a_ser_out, a_bit_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midreset_next: got ready/ser/bv=%b want 100", {a_in_ready, a_ser_out, a_bit_valid});
    end
    reset = 1'b0;
    exp_sent_a = 0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_frame_done || !a_in_ready) dones++;
    end
    tests_run++;
    if (dones != 0 || a_frames_sent !== 16'(exp_sent_a)) begin
      tests_failed++;
      $display("FAIL midreset_after: got done/busy=%0d frames_sent=%0d want 0/%0d", dones, a_frames_sent, exp_sent_a);
    end
  endtask

  // Instance B: no gap, 4-bit counter, 17 random words back-to-back.
  task automatic test_gap0_wrap();
    int prev, nacc, ndone, bad_period;
    logic [7:0] bits, exp;
    prev = -1; nacc = 0; ndone = 0; bad_period = 0; bits = '0;
    b_in_data = 8'($urandom_range(0, 255)); b_in_valid = 1'b1;
    for (int t = 0; t < 400 && ndone < 17; t++) begin
      if (b_bit_valid) bits = {bits[6:0], b_ser_out};
      if (b_frame_done) begin
        ndone++;
        exp = exp_q.pop_front();
        tests_run++;
        if (bits !== exp || (rem_b == 0) !== ((exp % 5) == 0)) begin
          tests_failed++;
          $display("FAIL gap0_frame[%0d]: got %b y=%b want %b y=%b", ndone, bits, rem_b == 0, exp, (exp % 5) == 0);
        end
      end
      if (b_in_ready && b_in_valid) begin
        if (prev >= 0 && t - prev != 11) bad_period++;
        prev = t;
        exp_q.push_back(b_in_data);
        nacc++;
      end else if (!b_in_ready) begin
        if (nacc == 17) b_in_valid = 1'b0;
        else b_in_data = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    tests_run++;
    if (ndone != 17 || nacc != 17 || bad_period != 0) begin
      tests_failed++;
      $display("FAIL gap0_period: got dones=%0d accepts=%0d bad_periods=%0d want 17/17/0", ndone, nacc, bad_period);
    end
    tests_run++;
    if (b_frames_sent !== 4'd1) begin
      tests_failed++;
      $display("FAIL gap0_wrap: got frames_sent=%0d want 1", b_frames_sent);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_words();
    test_toggle();
    test_back_to_back();
    test_reset_midframe();
    test_gap0_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog: a stuck handshake must still end the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
